counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//   Run/stop/clear/mode controller for the 0..9999 up/down display counter.
//   Turns three debounced button levels into the counter's control inputs:
//   a periodic count tick (while running), a one-cycle clear, and a mode level.
//   Sits between the button debouncers and the counter datapath.
// PARAMETERS
//   CLK_HZ   100_000_000  input clock frequency in Hz
//   TICK_HZ  10           count tick rate in Hz
//   DIV      CLK_HZ/TICK_HZ (derived localparam) clocks per tick; must be >= 2
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  asynchronous reset, active-low (0 = reset)
//   i_run_stop  in   1  debounced run/stop button level, synchronous to clk
//   i_clear     in   1  debounced clear button level, synchronous to clk
//   i_mode      in   1  debounced mode button level, synchronous to clk
//   o_tick      out  1  one-cycle count enable to counter (i_tick)
//   o_clear     out  1  one-cycle synchronous clear to counter (i_clear)
//   o_mode      out  1  count direction to counter (0 = up, 1 = down)
//   o_state     out  2  FSM state: 0 = STOP, 1 = RUN, 2 = CLEAR
// BEHAVIOUR
//   Reset (rst = 0, async):
//   - state = STOP, o_mode = 0, divider = 0, o_tick = 0, o_clear = 0.
//   - All edge-detect previous-level registers reset to 1. A button held
//     through reset release gives no event until it is released and pressed again.
//   Edge detect, per button:
//   - ev = level & ~prev. prev <= level every cycle.
//   - The event acts on the first edge that samples the level high.
//   - A held button gives exactly one event.
//   FSM (state register; 2'd3 is illegal and recovers to STOP next cycle):
//   - STOP:  ev_clear -> CLEAR. Else ev_run_stop -> RUN. Else ev_mode ->
//            toggle o_mode, stay in STOP.
//            Priority is clear > run_stop > mode. Any lower-priority event
//            in the same cycle is dropped; o_mode is unchanged.
//   - RUN:   ev_run_stop -> STOP. ev_clear and ev_mode are ignored
//            (no queuing).
//   - CLEAR: go to STOP on the next edge, unconditionally.
//            All events are ignored in this cycle.
//   Outputs:
//   - o_clear = (state == CLEAR). This is exactly one cycle per clear press.
//   - o_state = state register. o_mode is a register, toggled only as above.
//   Tick divider:
//   - Counter width $clog2(DIV). It is held at 0 whenever state != RUN.
//   - In RUN it counts 0..DIV-1 and wraps to 0.
//   - o_tick = (state == RUN) && (div == DIV-1). Combinational from registers.
//   - Timing: with the first RUN cycle numbered 1, o_tick is high in cycles
//     DIV, 2*DIV, 3*DIV, and so on.
//   - Leaving RUN discards the partial count. Re-entry restarts the full DIV period.
//   - If RUN->STOP happens on the same edge that ends a tick cycle, that tick
//     has already been issued; no further tick follows.
//   - o_tick and o_clear are never high in the same cycle.
// TESTING (bench uses CLK_HZ=100, TICK_HZ=10, so DIV=10)
//   1 Hold rst=0 with i_run_stop=1, then release and keep i_run_stop=1 for
//     5 cycles -> o_state=0, o_tick=o_clear=o_mode=0 throughout.
//     Drop i_run_stop and raise it again -> o_state=1 on that edge.
//   2 Press run (count the first RUN cycle as 1) -> o_tick in cycles 10 and 20.
//     Press stop at cycle 25 -> no tick in cycle 30, o_state=0.
//     Press run again -> next tick exactly 10 cycles after re-entry.
//   3 In STOP press clear -> o_state=2 and o_clear=1 for one cycle, then
//     o_state=0. In RUN press clear -> o_clear stays 0 and o_state stays 1.
//   4 In STOP hold i_mode for 20 cycles -> o_mode 0->1 once.
//     Press again -> 0. Press mode during RUN -> o_mode unchanged.
//   5 In STOP raise i_clear, i_run_stop and i_mode on the same edge ->
//     state goes to CLEAR, o_mode is unchanged, then STOP. No RUN entry.
//   6 Press run, then drive rst=0 mid-period after 7 RUN cycles -> o_tick=0
//     and o_state=0 immediately (async). After release, no tick until a new
//     run press.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// Button-level inputs and counter control outputs between the debouncers,
// counter_ctrl and the counter datapath.
interface counter_ctrl_if;
    logic       i_run_stop;
    logic       i_clear;
    logic       i_mode;
    logic       o_tick;
    logic       o_clear;
    logic       o_mode;
    logic [1:0] o_state;

    modport master (
        output i_run_stop, i_clear, i_mode,
        input  o_tick, o_clear, o_mode, o_state
    );

    modport slave (
        input  i_run_stop, i_clear, i_mode,
        output o_tick, o_clear, o_mode, o_state
    );
endinterface

// File: rtl/counter_ctrl.sv
// Run/stop/clear/mode controller: button edges drive a STOP/RUN/CLEAR FSM,
// a tick divider active only in RUN, and a direction register.
module counter_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic           clk,
    input  logic           rst,
    counter_ctrl_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    state_e        state_q;
    logic          mode_q;
    logic [DW-1:0] div_q;
    logic [2:0]    prev_q;
    logic [2:0]    lvl;
    logic          ev_run, ev_clr, ev_mode;

    assign lvl = {bus.i_run_stop, bus.i_clear, bus.i_mode};
    // prev resets high so a button held through reset release is not an event
    assign {ev_run, ev_clr, ev_mode} = lvl & ~prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
            mode_q  <= 1'b0;
            div_q   <= '0;
            prev_q  <= 3'b111;
        end else begin
            prev_q <= lvl;
            div_q  <= '0;
            case (state_q)
                ST_STOP: begin
                    if (ev_clr)       state_q <= ST_CLEAR;
                    else if (ev_run)  state_q <= ST_RUN;
                    else if (ev_mode) mode_q  <= ~mode_q;
                end
                ST_RUN: begin
                    // leaving RUN drops the partial period so re-entry starts fresh
                    if (ev_run) state_q <= ST_STOP;
                    else        div_q   <= (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
                end
                ST_CLEAR: state_q <= ST_STOP;
                default:  state_q <= ST_STOP;
            endcase
        end
    end

    assign bus.o_tick  = (state_q == ST_RUN) && (div_q == DIV_MAX);
    assign bus.o_clear = (state_q == ST_CLEAR);
    assign bus.o_mode  = mode_q;
    assign bus.o_state = state_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DIV = 10: a vector table for the
// FSM/edge-detect behaviour plus hand sequences for tick timing and async reset.
module tb_counter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    counter_ctrl_if bus ();

    counter_ctrl #(.CLK_HZ(100), .TICK_HZ(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, c, m;
        int         n;
        logic [1:0] st;
        logic       tk, cl, md;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] st, input logic tk,
                           input logic cl, input logic md);
        chk({name, ".state"}, int'(bus.o_state), int'(st));
        chk({name, ".tick"},  int'(bus.o_tick),  int'(tk));
        chk({name, ".clear"}, int'(bus.o_clear), int'(cl));
        chk({name, ".mode"},  int'(bus.o_mode),  int'(md));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic m);
        bus.i_run_stop = r;
        bus.i_clear    = c;
        bus.i_mode     = m;
    endtask

    // one run/stop press starting from low level; returns after the edge
    task automatic press_run();
        drive(1, 0, 0);
        step();
        drive(0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0);
        #1;
        chk_all("reset", 2'd0, 0, 0, 0);
        step();
        step();
        chk_all("reset_hold", 2'd0, 0, 0, 0);
        rst = 1'b1;

        //            r  c  m   n  st    tk cl md
        tbl.push_back('{1, 0, 0,  5, 2'd0, 0, 0, 0}); // held through reset: no event
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 0});
        tbl.push_back('{1, 0, 0,  1, 2'd1, 0, 0, 0}); // fresh press -> RUN
        tbl.push_back('{0, 0, 0,  1, 2'd1, 0, 0, 0});
        tbl.push_back('{0, 1, 0,  2, 2'd1, 0, 0, 0}); // clear ignored in RUN
        tbl.push_back('{0, 0, 1,  1, 2'd1, 0, 0, 0}); // mode ignored in RUN
        tbl.push_back('{0, 0, 0,  1, 2'd1, 0, 0, 0});
        tbl.push_back('{1, 0, 0,  1, 2'd0, 0, 0, 0}); // stop
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,  1, 2'd2, 0, 1, 0}); // clear from STOP
        tbl.push_back('{0, 1, 0,  1, 2'd0, 0, 0, 0}); // one cycle only while held
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 20, 2'd0, 0, 0, 1}); // held mode toggles once
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 1});
        tbl.push_back('{0, 0, 1,  1, 2'd0, 0, 0, 0}); // second press toggles back
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 0});
        tbl.push_back('{1, 1, 1,  1, 2'd2, 0, 1, 0}); // clear wins, mode dropped
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 0});
        tbl.push_back('{0, 1, 0,  1, 2'd2, 0, 1, 0});
        tbl.push_back('{1, 0, 1,  1, 2'd0, 0, 0, 0}); // events in CLEAR ignored
        tbl.push_back('{0, 0, 0,  2, 2'd0, 0, 0, 0});
        tbl.push_back('{1, 0, 0,  1, 2'd1, 0, 0, 0});
        tbl.push_back('{0, 0, 1,  1, 2'd1, 0, 0, 0});
        tbl.push_back('{1, 0, 0,  1, 2'd0, 0, 0, 0});
        tbl.push_back('{0, 0, 0,  1, 2'd0, 0, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].c, tbl[i].m);
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                chk_all($sformatf("vec%0d.%0d", i, k), tbl[i].st, tbl[i].tk, tbl[i].cl, tbl[i].md);
            end
        end

        // tick period: cycles 10 and 20, stop at 25, nothing at 30
        press_run();
        chk_all("tick.c1", 2'd1, 0, 0, 0);
        for (int c = 2; c <= 24; c++) begin
            step();
            chk_all($sformatf("tick.c%0d", c), 2'd1, (c % 10) == 0, 0, 0);
        end
        press_run();
        chk_all("tick.stop25", 2'd0, 0, 0, 0);
        for (int c = 26; c <= 35; c++) begin
            step();
            chk_all($sformatf("tick.idle%0d", c), 2'd0, 0, 0, 0);
        end

        // re-entry restarts the full period; stop on the tick edge gives no extra tick
        press_run();
        chk_all("rerun.c1", 2'd1, 0, 0, 0);
        for (int c = 2; c <= 20; c++) begin
            step();
            chk_all($sformatf("rerun.c%0d", c), 2'd1, (c % 10) == 0, 0, 0);
        end
        press_run();
        chk_all("rerun.stop_on_tick", 2'd0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            step();
            chk_all($sformatf("rerun.after%0d", c), 2'd0, 0, 0, 0);
        end

        // async reset mid-period after 7 RUN cycles
        press_run();
        for (int c = 2; c <= 7; c++) step();
        chk_all("arst.pre", 2'd1, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("arst.now", 2'd0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            chk_all($sformatf("arst.idle%0d", c), 2'd0, 0, 0, 0);
        end
        press_run();
        chk_all("arst.run1", 2'd1, 0, 0, 0);
        for (int c = 2; c <= 10; c++) begin
            step();
            chk_all($sformatf("arst.run%0d", c), 2'd1, c == 10, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
